// File: rtl/cond_pkg.sv
// Shared condition-code encodings, NZCV bit positions and the ARM condition evaluator.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic res;
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        res = 1'b0;
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = !z;
            COND_CS: res = c;
            COND_CC: res = !c;
            COND_MI: res = n;
            COND_PL: res = !n;
            COND_VS: res = v;
            COND_VC: res = !v;
            COND_HI: res = c && !z;
            COND_LS: res = !c || z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = !z && (n == v);
            COND_LE: res = z || (n != v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cond_eval_lane.sv
// One combinational query lane: decides hazard vs. pass for a single condition query.
module cond_eval_lane
    import cond_pkg::*;
(
    input  logic       valid_i,
    input  logic [3:0] cond_i,
    input  logic       resolved_i,
    input  logic [3:0] flags_i,
    output logic       pass_o,
    output logic       hazard_o
);

    // AL does not depend on flags, so it can never be stalled by in-flight writers.
    always_comb begin
        hazard_o = valid_i && (cond_i != COND_AL) && !resolved_i;
        pass_o   = valid_i && !hazard_o && cond_eval(cond_i, flags_i);
    end

endmodule

// File: rtl/cond_status_unit.sv
// NZCV status register, in-flight flag-setter tracking and NUM_PORTS registered condition
// queries. Define COND_BYPASS_EN to let a same-cycle flag write resolve queries.
module cond_status_unit
    import cond_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int PEND_DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flag_issue_i,
    input  logic                   flag_we_i,
    input  logic [3:0]             flag_wdata_i,
    input  logic [NUM_PORTS-1:0]   q_valid_i,
    input  logic [4*NUM_PORTS-1:0] q_cond_i,
    input  logic                   stall_i,
    output logic [NUM_PORTS-1:0]   r_valid_o,
    output logic [NUM_PORTS-1:0]   r_pass_o,
    output logic [NUM_PORTS-1:0]   r_hazard_o,
    output logic [3:0]             flags_o,
    output logic                   pend_full_o,
    output logic                   err_o
);

    localparam int PEND_W = $clog2(PEND_DEPTH + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(PEND_DEPTH);

    logic [3:0]           flags_q, flags_d;
    logic [PEND_W-1:0]    pend_q, pend_d;
    logic                 err_q, err_d;
    logic [NUM_PORTS-1:0] r_valid_q, r_valid_d;
    logic [NUM_PORTS-1:0] r_pass_q, r_pass_d;
    logic [NUM_PORTS-1:0] r_hazard_q, r_hazard_d;

    logic                 resolved;
    logic [3:0]           flags_src;
    logic [NUM_PORTS-1:0] lane_pass;
    logic [NUM_PORTS-1:0] lane_hazard;

    // Queries see the count before this cycle's issue: a same-cycle issue is younger.
`ifdef COND_BYPASS_EN
    assign resolved  = (pend_q == '0) || ((pend_q == PEND_W'(1)) && flag_we_i);
    assign flags_src = flag_we_i ? flag_wdata_i : flags_q;
`else
    assign resolved  = (pend_q == '0) && !flag_we_i;
    assign flags_src = flags_q;
`endif

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_lane
            cond_eval_lane u_lane (
                .valid_i    (q_valid_i[gi]),
                .cond_i     (q_cond_i[4*gi +: 4]),
                .resolved_i (resolved),
                .flags_i    (flags_src),
                .pass_o     (lane_pass[gi]),
                .hazard_o   (lane_hazard[gi])
            );
        end
    endgenerate

    always_comb begin
        flags_d = flag_we_i ? flag_wdata_i : flags_q;
        pend_d  = pend_q;
        err_d   = err_q;
        // Over/underflow holds the count and latches the sticky protocol error.
        if (flag_issue_i && !flag_we_i) begin
            if (pend_q == PEND_MAX) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (!flag_issue_i && flag_we_i) begin
            if (pend_q == '0) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q - PEND_W'(1);
            end
        end
    end

    always_comb begin
        r_valid_d  = r_valid_q;
        r_pass_d   = r_pass_q;
        r_hazard_d = r_hazard_q;
        if (!stall_i) begin
            r_valid_d  = q_valid_i;
            r_pass_d   = lane_pass;
            r_hazard_d = lane_hazard;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q    <= '0;
            pend_q     <= '0;
            err_q      <= 1'b0;
            r_valid_q  <= '0;
            r_pass_q   <= '0;
            r_hazard_q <= '0;
        end else begin
            flags_q    <= flags_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            r_valid_q  <= r_valid_d;
            r_pass_q   <= r_pass_d;
            r_hazard_q <= r_hazard_d;
        end
    end

    assign flags_o     = flags_q;
    assign pend_full_o = (pend_q == PEND_MAX);
    assign err_o       = err_q;
    assign r_valid_o   = r_valid_q;
    assign r_pass_o    = r_pass_q;
    assign r_hazard_o  = r_hazard_q;

endmodule

// File: tb/tb_cond_status_unit.sv
// Directed and randomized checks of cond_status_unit against a behavioural model.
module tb_cond_status_unit;

    logic       clk;
    logic       rst;
    logic       flag_issue_i;
    logic       flag_we_i;
    logic [3:0] flag_wdata_i;
    logic [1:0] q_valid_i;
    logic [7:0] q_cond_i;
    logic       stall_i;
    logic [1:0] r_valid_o;
    logic [1:0] r_pass_o;
    logic [1:0] r_hazard_o;
    logic [3:0] flags_o;
    logic       pend_full_o;
    logic       err_o;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [1:0] m_rv, m_rp, m_rh;
    logic [3:0] m_flags;
    int         m_pend;
    logic       m_err;

    cond_status_unit #(.NUM_PORTS(2), .PEND_DEPTH(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .flag_issue_i (flag_issue_i),
        .flag_we_i    (flag_we_i),
        .flag_wdata_i (flag_wdata_i),
        .q_valid_i    (q_valid_i),
        .q_cond_i     (q_cond_i),
        .stall_i      (stall_i),
        .r_valid_o    (r_valid_o),
        .r_pass_o     (r_pass_o),
        .r_hazard_o   (r_hazard_o),
        .flags_o      (flags_o),
        .pend_full_o  (pend_full_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_eval(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c & !z;
            4'h9: return !c | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit         res;
        logic [3:0] src;
        int         np;
        if (rst) begin
            m_rv = 0; m_rp = 0; m_rh = 0; m_flags = 0; m_pend = 0; m_err = 0;
        end else begin
`ifdef COND_BYPASS_EN
            res = (m_pend == 0) || (m_pend == 1 && flag_we_i);
            src = flag_we_i ? flag_wdata_i : m_flags;
`else
            res = (m_pend == 0) && !flag_we_i;
            src = m_flags;
`endif
            if (!stall_i) begin
                for (int p = 0; p < 2; p++) begin
                    logic [3:0] cc;
                    cc = q_cond_i[4*p +: 4];
                    m_rv[p] = q_valid_i[p];
                    m_rh[p] = q_valid_i[p] && (cc != 4'hE) && !res;
                    m_rp[p] = q_valid_i[p] && !m_rh[p] && ref_eval(cc, src);
                end
            end
            if (flag_we_i) m_flags = flag_wdata_i;
            np = m_pend + int'(flag_issue_i) - int'(flag_we_i);
            if (np < 0 || np > 3) m_err = 1'b1;
            else m_pend = np;
        end
    endtask

    task automatic cycle(input logic i_rst, input logic i_issue, input logic i_we,
                         input logic [3:0] i_wd, input logic [1:0] i_qv,
                         input logic [7:0] i_qc, input logic i_stall);
        rst = i_rst; flag_issue_i = i_issue; flag_we_i = i_we; flag_wdata_i = i_wd;
        q_valid_i = i_qv; q_cond_i = i_qc; stall_i = i_stall;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 4'hF, 2'b11, 8'hEE, 0);
        cycle(1, 1, 1, 4'hF, 2'b11, 8'hEE, 0);
        checks++;
        if ({r_valid_o, r_pass_o, r_hazard_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_r: got %b/%b/%b want 00/00/00", r_valid_o, r_pass_o, r_hazard_o);
        end
        checks++;
        if ({flags_o, pend_full_o, err_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: flags=%b full=%b err=%b want 0000/0/0", flags_o, pend_full_o, err_o);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_eq_ne();
        cycle(0, 1, 0, 4'h0, 0, 0, 0);
        cycle(0, 0, 1, 4'b0100, 0, 0, 0);
        cycle(0, 0, 0, 4'h0, 0, 0, 0);
        cycle(0, 0, 0, 4'h0, 2'b11, {4'h1, 4'h0}, 0);
        checks++;
        if (r_pass_o !== 2'b01 || r_hazard_o !== 2'b00) begin
            errors++;
            $display("FAIL eq_ne: pass=%b hazard=%b want 01/00", r_pass_o, r_hazard_o);
        end
        $display("eq_ne: flags=%b pass=%b hazard=%b", flags_o, r_pass_o, r_hazard_o);
    endtask

    task automatic test_gt_le();
        cycle(0, 1, 0, 4'h0, 0, 0, 0);
        cycle(0, 0, 1, 4'b1001, 0, 0, 0);
        cycle(0, 0, 0, 4'h0, 0, 0, 0);
        cycle(0, 0, 0, 4'h0, 2'b11, {4'hD, 4'hC}, 0);
        checks++;
        if (r_pass_o !== 2'b01 || r_hazard_o !== 2'b00) begin
            errors++;
            $display("FAIL gt_le_nz: pass=%b hazard=%b want 01/00", r_pass_o, r_hazard_o);
        end
        cycle(0, 1, 0, 4'h0, 0, 0, 0);
        cycle(0, 0, 1, 4'b1101, 0, 0, 0);
        cycle(0, 0, 0, 4'h0, 0, 0, 0);
        cycle(0, 0, 0, 4'h0, 2'b11, {4'hD, 4'hC}, 0);
        checks++;
        if (r_pass_o !== 2'b10 || r_hazard_o !== 2'b00) begin
            errors++;
            $display("FAIL gt_le_z: pass=%b hazard=%b want 10/00", r_pass_o, r_hazard_o);
        end
        $display("gt_le: flags=%b pass=%b", flags_o, r_pass_o);
    endtask

    task automatic test_bypass();
        cycle(0, 1, 0, 4'h0, 0, 0, 0);
        cycle(0, 0, 1, 4'b0000, 0, 0, 0);
        cycle(0, 0, 0, 4'h0, 0, 0, 0);
        cycle(0, 1, 0, 4'h0, 0, 0, 0);
        cycle(0, 0, 1, 4'b0100, 2'b01, 8'h00, 0);
`ifdef COND_BYPASS_EN
        checks++;
        if (r_hazard_o !== 2'b00 || r_pass_o !== 2'b01) begin
            errors++;
            $display("FAIL bypass_hit: hazard=%b pass=%b want 00/01", r_hazard_o, r_pass_o);
        end
`else
        checks++;
        if (r_hazard_o !== 2'b01 || r_pass_o !== 2'b00) begin
            errors++;
            $display("FAIL bypass_hazard: hazard=%b pass=%b want 01/00", r_hazard_o, r_pass_o);
        end
`endif
        cycle(0, 0, 0, 4'h0, 2'b01, 8'h00, 0);
        checks++;
        if (r_hazard_o !== 2'b00 || r_pass_o !== 2'b01) begin
            errors++;
            $display("FAIL bypass_requery: hazard=%b pass=%b want 00/01", r_hazard_o, r_pass_o);
        end
        $display("bypass: flags=%b hazard=%b pass=%b", flags_o, r_hazard_o, r_pass_o);
    endtask

    task automatic test_counter();
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (pend_full_o !== 1'b0) begin
            errors++;
            $display("FAIL pend_two: full=%b want 0", pend_full_o);
        end
        cycle(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (pend_full_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL pend_full: full=%b err=%b want 1/0", pend_full_o, err_o);
        end
        cycle(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (err_o !== 1'b1 || pend_full_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow: err=%b full=%b want 1/1", err_o, pend_full_o);
        end
        cycle(0, 1, 1, 4'h3, 0, 0, 0);
        checks++;
        if (pend_full_o !== 1'b1) begin
            errors++;
            $display("FAIL issue_we: full=%b want 1", pend_full_o);
        end
        cycle(0, 0, 1, 4'h3, 0, 0, 0);
        checks++;
        if (pend_full_o !== 1'b0) begin
            errors++;
            $display("FAIL drain: full=%b want 0", pend_full_o);
        end
        cycle(0, 0, 1, 4'h3, 0, 0, 0);
        cycle(0, 0, 1, 4'h3, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b want 0", err_o);
        end
        cycle(0, 0, 1, 4'b1010, 0, 0, 0);
        checks++;
        if (err_o !== 1'b1 || flags_o !== 4'b1010 || pend_full_o !== 1'b0) begin
            errors++;
            $display("FAIL underflow: err=%b flags=%b full=%b want 1/1010/0", err_o, flags_o, pend_full_o);
        end
        $display("counter: err=%b flags=%b full=%b", err_o, flags_o, pend_full_o);
        cycle(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_stall_al();
        logic [5:0] held;
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 2'b11, {4'h0, 4'hE}, 0);
        checks++;
        if (r_valid_o !== 2'b11 || r_pass_o !== 2'b01 || r_hazard_o !== 2'b10) begin
            errors++;
            $display("FAIL al_pend: valid=%b pass=%b hazard=%b want 11/01/10", r_valid_o, r_pass_o, r_hazard_o);
        end
        held = {r_valid_o, r_pass_o, r_hazard_o};
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, (k == 0), 4'b0110, 2'b10, {4'hE, 4'hF}, 1);
            checks++;
            if ({r_valid_o, r_pass_o, r_hazard_o} !== held) begin
                errors++;
                $display("FAIL stall_hold%0d: got %b want %b", k, {r_valid_o, r_pass_o, r_hazard_o}, held);
            end
        end
        checks++;
        if (flags_o !== 4'b0110) begin
            errors++;
            $display("FAIL stall_flags: flags=%b want 0110", flags_o);
        end
        $display("stall_al: r=%b flags=%b", {r_valid_o, r_pass_o, r_hazard_o}, flags_o);
        cycle(0, 0, 1, 4'b0110, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0), 4'($urandom), 2'($urandom),
                  8'($urandom), ($urandom_range(0, 5) == 0));
            checks++;
            if (r_valid_o !== m_rv || r_pass_o !== m_rp || r_hazard_o !== m_rh) begin
                errors++;
                $display("FAIL rand_r%0d: got %b/%b/%b want %b/%b/%b", n,
                         r_valid_o, r_pass_o, r_hazard_o, m_rv, m_rp, m_rh);
            end
            checks++;
            if (flags_o !== m_flags || pend_full_o !== (m_pend == 3) || err_o !== m_err) begin
                errors++;
                $display("FAIL rand_state%0d: got %b/%b/%b want %b/%b/%b", n,
                         flags_o, pend_full_o, err_o, m_flags, (m_pend == 3), m_err);
            end
        end
        $display("random: 400 cycles done");
    endtask

    initial begin
        rst = 1; flag_issue_i = 0; flag_we_i = 0; flag_wdata_i = 0;
        q_valid_i = 0; q_cond_i = 0; stall_i = 0;
        m_rv = 0; m_rp = 0; m_rh = 0; m_flags = 0; m_pend = 0; m_err = 0;
        test_reset();
        test_eq_ne();
        test_gt_le();
        test_bypass();
        test_counter();
        test_stall_al();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
